// File: rtl/dac_sample_ctrl.sv
// DAC sample controller: SPI-mode-0 slave feeding a sample FIFO drained by a programmable tick,
// with a direct-drive bypass mode and a status readback byte on MISO.
module dac_sample_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_b,
  output logic                          spi_miso,
  input  logic [7:0]                    d_direct,
  output logic [7:0]                    d_out,
  output logic                          sample_stb,
  output logic                          underrun,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, csb_sync_q, csb_sync_d;
  logic sclk_prev_q, csb_prev_q, armed_q, armed_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  miso_sr_q, miso_sr_d;
  logic [7:0]  div_q, div_d, tick_q, tick_d;
  logic        mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  d_out_q, d_out_d;
  logic        stb_q, stb_d, ovf_q, ovf_d, unf_q, unf_d;

  logic sclk_s, mosi_s, csb_s, sclk_rise, sclk_fall, csb_fall;
  logic is_cfg, push, div_wr, ctrl_wr, flush, clr_flags, pop_req;
  logic empty, full, pop_ok, push_ok;
  logic [3:0] lvl_sat;
  logic unused_rx;

  // cs_b chain resets low so a cs_b held low across reset never looks like a fresh falling edge
  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, spi_sclk});
    mosi_sync_d = SYNC_STAGES'({mosi_sync_q, spi_mosi});
    csb_sync_d  = SYNC_STAGES'({csb_sync_q, spi_cs_b});
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;
  assign unused_rx = ^rx_sr_q[11:8];

  always_comb begin
    armed_d      = armed_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    frame_done_d = 1'b0;
    miso_sr_d    = miso_sr_q;
    if (csb_s) begin
      armed_d   = 1'b0;
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else begin
      if (csb_fall) armed_d = 1'b1;
      if (armed_q && sclk_rise && bit_cnt_q != 5'd16) begin
        rx_sr_d      = {rx_sr_q[14:0], mosi_s};
        bit_cnt_d    = bit_cnt_q + 5'd1;
        frame_done_d = (bit_cnt_q == 5'd15);
      end
    end
    if (csb_fall) miso_sr_d = {ovf_q, unf_q, 2'b00, lvl_sat};
    else if (!csb_s && sclk_fall) miso_sr_d = {miso_sr_q[6:0], 1'b0};
  end

  always_comb begin
    lvl_sat = 4'(level_q);
    if (32'(level_q) > 32'd15) lvl_sat = 4'hF;
  end

  assign is_cfg    = frame_done_q & rx_sr_q[15];
  assign push      = frame_done_q & ~rx_sr_q[15];
  assign div_wr    = is_cfg & (rx_sr_q[14:12] == 3'd0);
  assign ctrl_wr   = is_cfg & (rx_sr_q[14:12] == 3'd1);
  assign flush     = ctrl_wr & rx_sr_q[2];
  assign clr_flags = ctrl_wr & rx_sr_q[1];

  always_comb begin
    div_d   = div_wr  ? rx_sr_q[7:0] : div_q;
    mode_d  = ctrl_wr ? rx_sr_q[0]   : mode_q;
    tick_d  = tick_q;
    pop_req = 1'b0;
    if (div_wr) begin
      tick_d = '0;
    end else if (ena && mode_q) begin
      if (tick_q == div_q) begin
        pop_req = 1'b1;
        tick_d  = '0;
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end
  end

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop_ok  = pop_req & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    d_out_d  = d_out_q;
    stb_d    = 1'b0;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    if (!mode_q) begin
      d_out_d = d_direct;
    end else if (pop_ok) begin
      d_out_d = mem_q[rd_ptr_q];
      stb_d   = 1'b1;
    end
    ovf_d = clr_flags ? 1'b0 : (ovf_q | (push & full & ~pop_ok & ~flush));
    unf_d = clr_flags ? 1'b0 : (unf_q | (pop_req & empty & ~flush));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      csb_sync_q   <= '0;
      sclk_prev_q  <= 1'b0;
      csb_prev_q   <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      frame_done_q <= 1'b0;
      miso_sr_q    <= '0;
      div_q        <= 8'd4;
      mode_q       <= 1'b0;
      tick_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      d_out_q      <= 8'h80;
      stb_q        <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      csb_sync_q   <= csb_sync_d;
      sclk_prev_q  <= sclk_s;
      csb_prev_q   <= csb_s;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      frame_done_q <= frame_done_d;
      miso_sr_q    <= miso_sr_d;
      div_q        <= div_d;
      mode_q       <= mode_d;
      tick_q       <= tick_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      d_out_q      <= d_out_d;
      stb_q        <= stb_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_sr_q[7:0];
  end

  assign spi_miso   = ~csb_s & miso_sr_q[7];
  assign d_out      = d_out_q;
  assign sample_stb = stb_q;
  assign underrun   = unf_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_sample_ctrl.sv
// Bench for dac_sample_ctrl: direct-mode vector table, SPI bit-banged frames, and a
// scoreboard queue of pushed samples checked against every sample_stb.
module tb_dac_sample_ctrl;
  logic       clk = 1'b0;
  logic       rst, ena, spi_sclk, spi_mosi, spi_cs_b, spi_miso;
  logic [7:0] d_direct, d_out;
  logic       sample_stb, underrun, overflow;
  logic [3:0] fifo_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  dac_sample_ctrl #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_b(spi_cs_b), .spi_miso(spi_miso),
    .d_direct(d_direct), .d_out(d_out), .sample_stb(sample_stb),
    .underrun(underrun), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // every strobe must match the oldest sample the bench expects to leave the FIFO
  always @(negedge clk) begin
    if (!rst && sample_stb) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stb_unexpected: got d_out=0x%0h with no sample expected", d_out);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("fifo_data", {24'd0, d_out}, {24'd0, e});
      end
    end
  end

  task automatic spi_xfer(input logic [15:0] w, input int nbits, input int rst_at,
                          input bit ena_pulse, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    spi_cs_b = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      spi_mosi = w[15-i];
      repeat (4) @(negedge clk);
      if (i < 8) rd[7-i] = spi_miso;
      spi_sclk = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        // enable exactly the cycle in which the 16th-bit push is acted on
        if (ena_pulse && i == nbits - 1) begin
          if (j == 2) ena = 1'b1;
          if (j == 3) ena = 1'b0;
        end
      end
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w);
    logic [7:0] d;
    spi_xfer(w, 16, -1, 1'b0, d);
  endtask

  task automatic push_sample(input logic [7:0] v, input bit keep);
    if (keep) sb.push_back(v);
    send({8'h00, v});
  endtask

  task automatic wait_stb(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_stb) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL stb_timeout: got no sample_stb within %0d cycles, required one", budget);
  endtask

  initial begin
    int t0, t1, t2;
    logic [7:0] rd;

    vecs[0] = '{8'h3C, 8'h3C};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'hA5, 8'hA5};
    vecs[4] = '{8'h5A, 8'h5A};
    vecs[5] = '{8'h01, 8'h01};

    rst = 1'b1; ena = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_b = 1'b1; d_direct = 8'h11;
    repeat (3) @(negedge clk);
    chk("rst_d_out", {24'd0, d_out}, 32'h80);
    chk("rst_stb", {31'd0, sample_stb}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d_direct = vecs[i].din;
      @(negedge clk);
      chk("direct_d_out", {24'd0, d_out}, {24'd0, vecs[i].exp});
    end

    // paced FIFO playback at DIV=2, then one underrun tick
    send(16'h8002);
    push_sample(8'h10, 1'b1);
    push_sample(8'h20, 1'b1);
    push_sample(8'h30, 1'b1);
    chk("level_after_3", {28'd0, fifo_level}, 32'd3);
    send(16'h9001);
    ena = 1'b1;
    wait_stb(20, t0);
    wait_stb(20, t1);
    wait_stb(20, t2);
    chk("stb_interval_1", t1 - t0, 32'd3);
    chk("stb_interval_2", t2 - t1, 32'd3);
    repeat (5) @(negedge clk);
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    chk("d_out_hold", {24'd0, d_out}, 32'h30);
    chk("level_empty", {28'd0, fifo_level}, 32'd0);
    ena = 1'b0;

    // overflow in direct mode: ninth sample dropped
    send(16'h9002);
    chk("clear_underrun", {31'd0, underrun}, 32'd0);
    for (int i = 0; i < 9; i++) push_sample(8'h41 + 8'(i), i < 8);
    chk("level_full", {28'd0, fifo_level}, 32'd8);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    spi_xfer(16'hF000, 16, -1, 1'b0, rd);
    chk("status_full", {24'd0, rd}, 32'h88);

    send(16'h9001);
    ena = 1'b1;
    wait_stb(20, t0);
    wait_stb(20, t0);
    wait_stb(20, t0);
    ena = 1'b0;
    @(negedge clk);
    chk("level_5", {28'd0, fifo_level}, 32'd5);
    spi_xfer(16'hF000, 16, -1, 1'b0, rd);
    chk("status_85", {24'd0, rd}, 32'h85);
    send(16'h9003);
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_underrun", {31'd0, underrun}, 32'd0);
    ena = 1'b1;
    for (int i = 0; i < 5; i++) wait_stb(20, t0);
    ena = 1'b0;
    @(negedge clk);
    chk("drained_level", {28'd0, fifo_level}, 32'd0);
    chk("drained_underrun", {31'd0, underrun}, 32'd0);

    // aborted frames leave no trace
    send(16'h9000);
    spi_xfer(16'h00AA, 10, -1, 1'b0, rd);
    chk("abort_level", {28'd0, fifo_level}, 32'd0);
    spi_xfer(16'h8000, 10, -1, 1'b0, rd);
    push_sample(8'hAA, 1'b1);
    chk("level_after_aa", {28'd0, fifo_level}, 32'd1);

    // full FIFO, DIV=0: push coincides with a pop
    for (int i = 0; i < 7; i++) push_sample(8'h51 + 8'(i), 1'b1);
    chk("level_full2", {28'd0, fifo_level}, 32'd8);
    send(16'h8000);
    send(16'h9001);
    sb.push_back(8'h58);
    spi_xfer(16'h0058, 16, -1, 1'b1, rd);
    chk("full_pushpop_level", {28'd0, fifo_level}, 32'd8);
    chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
    send(16'h9004);
    sb.delete();
    chk("flush_level", {28'd0, fifo_level}, 32'd0);

    // reset mid-frame discards the frame and needs a new cs_b fall
    d_direct = 8'h66;
    spi_xfer(16'h0055, 16, 8, 1'b0, rd);
    sb.delete();
    chk("midrst_level", {28'd0, fifo_level}, 32'd0);
    chk("midrst_d_out", {24'd0, d_out}, 32'h66);
    push_sample(8'h77, 1'b0);
    chk("post_rst_level", {28'd0, fifo_level}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish by time limit, required finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dac_sample_ctrl.md
DAC_SAMPLE_CTRL -- requirements
Module: dac_sample_ctrl

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 8, sample FIFO entries (power of 2). SYNC_STAGES, default 2, SPI input synchronizer depth.
REQ-002 SHALL have port: clk  in  1  single system clock; all logic rising-edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: ena  in  1  block enable; when 0, tick counter and FIFO pops are frozen.
REQ-005 SHALL have ports: spi_sclk, spi_mosi, spi_cs_b  in  1 each  SPI mode-0 slave inputs, asynchronous to clk.
REQ-006 SHALL have port: spi_miso  out  1  status readback.
REQ-007 SHALL have port: d_direct  in  8  unsigned sample for direct mode.
REQ-008 SHALL have port: d_out  out  8  registered unsigned sample to DAC data input.
REQ-009 SHALL have ports: sample_stb  out  1  one-cycle pulse when d_out is updated from the FIFO. underrun  out  1  sticky. overflow  out  1  sticky. fifo_level  out  log2(FIFO_DEPTH)+1  entries held.

Function
REQ-010 SHALL synchronize spi_sclk, spi_mosi and spi_cs_b through SYNC_STAGES flops; sclk edges SHALL be detected from the synchronized sclk (requires f_clk >= 4x f_sclk).
REQ-011 SHALL sample MOSI MSB-first on each synchronized sclk rising edge while cs_b=0; cs_b=1 SHALL clear the bit counter and shift register.
REQ-012 SHALL act on a frame only on the 16th rising edge; frames aborted (cs_b rises) before 16 bits SHALL be discarded with no side effects; bits beyond 16 SHALL be ignored until cs_b rises.
REQ-013 Frame bit15=0 (data): bits[7:0] SHALL be pushed to the FIFO the cycle after the 16th edge.
REQ-014 Frame bit15=1 (config): bits[14:12]=0 writes DIV<=bits[7:0] and clears tick counter. =1 writes CTRL: bit0 mode_fifo, bit1 clear_flags (self-clearing), bit2 flush (self-clearing, empties FIFO). Other addresses SHALL be ignored.
REQ-015 On cs_b falling, SHALL load status byte {overflow, underrun, 2'b00, fifo_level[3:0]} (level saturated to 15) into MISO shifter; drive MSB immediately, shift on each sclk falling edge; after 8 bits drive 0; spi_miso=0 when cs_b=1.
REQ-016 Tick counter SHALL count 0..DIV while ena=1 and mode_fifo=1; the cycle count==DIV SHALL produce a pop request and reload 0; DIV=0 requests every cycle.
REQ-017 Pop request with FIFO non-empty: d_out<=head entry, sample_stb=1 next cycle, level decrements.
REQ-018 Pop request with FIFO empty: d_out SHALL hold its value, sample_stb=0, underrun set.
REQ-019 Push with FIFO full and no same-cycle pop: data dropped, FIFO unchanged, overflow set.
REQ-020 Simultaneous push and pop: full -> both succeed, no overflow. Empty -> pop sees pre-cycle empty (underrun set), push accepted, level=1.
REQ-021 Direct mode (mode_fifo=0): d_out<=d_direct every cycle (1-cycle latency), sample_stb=0, no pops; FIFO pushes still accepted.
REQ-022 Mode changes SHALL not flush the FIFO. Flush and clear_flags SHALL take priority over a same-cycle push/pop or flag set.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.

Reset
REQ-024 rst=1 SHALL set: d_out=8'h80, sample_stb=0, underrun=0, overflow=0, fifo_level=0, spi_miso=0, DIV=8'd4, mode_fifo=0, tick counter 0, SPI shifters cleared.
REQ-025 rst asserted mid-frame SHALL discard the frame. Following release, a frame SHALL be accepted only after a fresh cs_b falling edge.

Verification
REQ-026 Reset -> d_out=0x80, all flags 0. Direct mode, d_direct=0x3C -> d_out=0x3C one cycle later.
REQ-027 Write DIV=2, CTRL=0x01. Push 0x10,0x20,0x30 -> sample_stb every 3 cycles, d_out 0x10,0x20,0x30. Next tick: d_out holds 0x30, underrun=1.
REQ-028 Mode_fifo=0. Push 9 samples into depth-8 FIFO -> fifo_level=8, overflow=1. Pop order returns first 8 values only.
REQ-029 Frame aborted after 10 bits -> no push, no register change. Then 16-bit frame 0x00AA -> level +1.
REQ-030 Read status with overflow=1, level=5 -> MISO byte 0x85. CTRL=0x03 -> flags cleared, mode_fifo remains 1.
REQ-031 FIFO full with DIV=0 and a push landing on a pop cycle -> level stays 8, overflow=0. Flush -> level=0.
